// File: rtl/simple_prog_loader.sv
// Simple program loader.
// Assembles a byte stream (high byte first) into 16-bit instruction words,
// writes each word into instruction memory, and then releases the CPU core
// from reset once the final word has landed.
module simple_prog_loader #(
  parameter int IMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        s_ready,
  output logic        imem_wren,
  output logic [7:0]  imem_waddr,
  output logic [15:0] imem_wdata,
  output logic        cpu_resetn,
  output logic        load_done,
  output logic [8:0]  word_count,
  output logic        err_odd,
  output logic        err_overflow
);

  // Loader states: collect high byte, collect low byte, strobe memory, run CPU
  localparam logic [1:0] ST_GET_HI = 2'd0;
  localparam logic [1:0] ST_GET_LO = 2'd1;
  localparam logic [1:0] ST_WRITE  = 2'd2;
  localparam logic [1:0] ST_RUN    = 2'd3;

  // Memory capacity expressed in the word counter's width
  localparam logic [8:0] DEPTH_WORDS = 9'(IMEM_DEPTH);

  logic [1:0]  r_state;
  logic [1:0]  w_nextState;
  logic [7:0]  r_wrPtr;
  logic [8:0]  r_wordCount;
  logic [7:0]  r_hiByte;
  logic [7:0]  r_loByte;
  logic        r_lastSeen;
  logic        r_sReady;
  logic        r_wren;
  logic [7:0]  r_waddr;
  logic [15:0] r_wdata;
  logic        r_cpuResetn;
  logic        r_loadDone;
  logic        r_errOdd;
  logic        r_errOverflow;

  logic        w_inLoad;
  logic        w_xfer;
  logic [8:0]  w_countInc;
  logic        w_full;

  // A byte is only taken while collecting and when both sides agree
  assign w_inLoad   = (r_state == ST_GET_HI) || (r_state == ST_GET_LO);
  assign w_xfer     = s_valid & r_sReady & w_inLoad;
  assign w_countInc = r_wordCount + 9'd1;
  assign w_full     = (w_countInc == DEPTH_WORDS);

  // Next-state selection; WRITE always lasts one cycle and RUN is terminal
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_GET_HI: begin
        if (w_xfer) begin
          w_nextState = s_last ? ST_WRITE : ST_GET_LO;
        end
      end
      ST_GET_LO: begin
        if (w_xfer) begin
          w_nextState = ST_WRITE;
        end
      end
      ST_WRITE: begin
        w_nextState = (r_lastSeen || w_full) ? ST_RUN : ST_GET_HI;
      end
      default: begin
        w_nextState = ST_RUN;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_GET_HI;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Ready and write strobe are registered from the next state so they line up
  // with the state they belong to; ready stays low until the first edge after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sReady <= 1'b0;
      r_wren   <= 1'b0;
    end else begin
      r_sReady <= (w_nextState == ST_GET_HI) || (w_nextState == ST_GET_LO);
      r_wren   <= (w_nextState == ST_WRITE);
    end
  end

  // Byte capture and word assembly; address/data are loaded only when a word
  // completes, so they hold their previous values whenever the strobe is low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hiByte   <= 8'h00;
      r_loByte   <= 8'h00;
      r_lastSeen <= 1'b0;
      r_waddr    <= 8'h00;
      r_wdata    <= 16'h0000;
    end else if (w_xfer) begin
      if (r_state == ST_GET_HI) begin
        r_hiByte <= s_data;
        if (s_last) begin
          r_loByte   <= 8'h00;
          r_lastSeen <= 1'b1;
          r_waddr    <= r_wrPtr;
          r_wdata    <= {s_data, 8'h00};
        end
      end else begin
        r_loByte   <= s_data;
        r_lastSeen <= s_last;
        r_waddr    <= r_wrPtr;
        r_wdata    <= {r_hiByte, s_data};
      end
    end
  end

  // Write pointer and word counter advance as each write completes; the
  // pointer holds at the top address so it can never wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr     <= 8'h00;
      r_wordCount <= 9'd0;
    end else if (r_state == ST_WRITE) begin
      r_wordCount <= w_countInc;
      if (!w_full) begin
        r_wrPtr <= r_wrPtr + 8'd1;
      end
    end
  end

  // Sticky error flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_errOdd      <= 1'b0;
      r_errOverflow <= 1'b0;
    end else begin
      if (w_xfer && (r_state == ST_GET_HI) && s_last) begin
        r_errOdd <= 1'b1;
      end
      if ((r_state == ST_WRITE) && w_full && !r_lastSeen) begin
        r_errOverflow <= 1'b1;
      end
    end
  end

  // CPU release: both flags follow the RUN state one cycle late and stay set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_loadDone  <= 1'b0;
      r_cpuResetn <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_loadDone  <= 1'b1;
      r_cpuResetn <= 1'b1;
    end
  end

  assign s_ready      = r_sReady;
  assign imem_wren    = r_wren;
  assign imem_waddr   = r_waddr;
  assign imem_wdata   = r_wdata;
  assign cpu_resetn   = r_cpuResetn;
  assign load_done    = r_loadDone;
  assign word_count   = r_wordCount;
  assign err_odd      = r_errOdd;
  assign err_overflow = r_errOverflow;

endmodule

// File: tb/tb_simple_prog_loader.sv
// Testbench for simple_prog_loader: drives byte streams with random stalls and
// compares the memory writes and status flags with a byte-pairing model.
module tb_simple_prog_loader;

  localparam int DEPTH = 256;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic        imem_wren;
  logic [7:0]  imem_waddr;
  logic [15:0] imem_wdata;
  logic        cpu_resetn;
  logic        load_done;
  logic [8:0]  word_count;
  logic        err_odd;
  logic        err_overflow;

  int checks = 0;
  int errors = 0;

  logic [7:0] streamBytes[$];
  wr_t        gotWrites[$];
  wr_t        expWrites[$];
  int         expAccepted;
  logic       expOdd;
  logic       expOvf;
  int         acceptCount;
  int         cycleCnt;
  int         lastWrCycle;
  int         doneCycle;
  logic       prevWren;
  logic       prevDone;

  simple_prog_loader #(.IMEM_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .imem_wren    (imem_wren),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .cpu_resetn   (cpu_resetn),
    .load_done    (load_done),
    .word_count   (word_count),
    .err_odd      (err_odd),
    .err_overflow (err_overflow)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Monitor: records writes and accepted bytes, checks the always-true properties
  always @(negedge clk) begin
    if (reset) begin
      prevWren = 1'b0;
    end else begin
      cycleCnt++;
      if (s_valid && s_ready) acceptCount++;
      if (imem_wren) begin
        gotWrites.push_back({imem_waddr, imem_wdata});
        lastWrCycle = cycleCnt;
      end
      if (load_done && !prevDone) doneCycle = cycleCnt;
      checks += 3;
      if (imem_wren && prevWren) begin
        errors++;
        $display("[TB] FAIL wren_width: wren high %0d cycles in a row, required 1", 2);
      end
      if (!load_done && cpu_resetn !== 1'b0) begin
        errors++;
        $display("[TB] FAIL cpu_hold: cpu_resetn=%b with load_done=0, required 0", cpu_resetn);
      end
      if ((imem_wren || load_done) && s_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL ready_busy: s_ready=%b during write/run, required 0", s_ready);
      end
      prevWren = imem_wren;
      prevDone = load_done;
    end
  end

  // Reference model: pair bytes high-first, pad a lone final byte with 0x00,
  // stop at memory capacity; anything left over is an overflow
  task automatic build_expected();
    int i = 0;
    int n = streamBytes.size();
    expWrites.delete();
    expOdd = 1'b0;
    while (i < n && expWrites.size() < DEPTH) begin
      if (i == n - 1) begin
        expWrites.push_back({8'(expWrites.size()), streamBytes[i], 8'h00});
        expOdd = 1'b1;
        i += 1;
      end else begin
        expWrites.push_back({8'(expWrites.size()), streamBytes[i], streamBytes[i+1]});
        i += 2;
      end
    end
    expAccepted = i;
    expOvf = (i < n);
  endtask

  // Reset the DUT and the monitor bookkeeping; returns one edge after release
  task automatic do_reset();
    reset   = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    gotWrites.delete();
    acceptCount = 0;
    cycleCnt    = 0;
    lastWrCycle = -1;
    doneCycle   = -1;
    prevDone    = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // Stream streamBytes into the loader; mode 0 no stalls, 1 alternate, 2 random
  task automatic drive_stream(input int mode, input int stallPct);
    int  idx = 0;
    int  cyc = 0;
    int  waitCyc = 0;
    int  n = streamBytes.size();
    bit  tog = 1'b0;
    bit  stall;
    while (idx < n && !load_done && cyc < 5000) begin
      stall = (mode == 1) ? tog : (mode == 2) ? ($urandom_range(99) < stallPct) : 1'b0;
      tog = ~tog;
      if (stall) begin
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        s_last  = 1'($urandom);
      end else begin
        s_valid = 1'b1;
        s_data  = streamBytes[idx];
        s_last  = (idx == n - 1);
      end
      @(negedge clk);
      if (s_valid && s_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    while (waitCyc < 40 && !(load_done && waitCyc >= 8)) begin
      if (idx < n) begin
        s_valid = 1'b1;
        s_data  = streamBytes[idx];
        s_last  = (idx == n - 1);
      end else begin
        s_valid = 1'b0;
        s_last  = 1'b0;
      end
      @(posedge clk); #1;
      waitCyc++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    checks++;
    if (load_done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL load_timeout: load_done=%b after stream, required 1", load_done);
    end
  endtask

  // Asynchronous reset values and ready rising on the first edge after release
  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({s_ready, imem_wren, imem_waddr, imem_wdata, cpu_resetn, load_done,
         word_count, err_odd, err_overflow} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: rdy=%b wren=%b addr=%h data=%h rstn=%b done=%b cnt=%0d odd=%b ovf=%b, required all 0",
               s_ready, imem_wren, imem_waddr, imem_wdata, cpu_resetn, load_done,
               word_count, err_odd, err_overflow);
    end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ready_before_edge: s_ready=%b, required 0", s_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_after_edge: s_ready=%b, required 1", s_ready);
    end
  endtask

  // Two full words with s_valid held high
  task automatic test_basic();
    do_reset();
    streamBytes = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    drive_stream(0, 0);
    checks++;
    if (gotWrites.size() != 2) begin
      errors++;
      $display("[TB] FAIL basic_count: %0d writes, required 2", gotWrites.size());
    end else begin
      checks += 2;
      if (gotWrites[0] !== {8'h00, 16'h1234}) begin
        errors++;
        $display("[TB] FAIL basic_w0: got %h, required 001234", gotWrites[0]);
      end
      if (gotWrites[1] !== {8'h01, 16'hABCD}) begin
        errors++;
        $display("[TB] FAIL basic_w1: got %h, required 01abcd", gotWrites[1]);
      end
    end
    checks++;
    if (word_count !== 9'd2 || err_odd !== 1'b0 || err_overflow !== 1'b0 || cpu_resetn !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_status: cnt=%0d odd=%b ovf=%b rstn=%b, required 2 0 0 1",
               word_count, err_odd, err_overflow, cpu_resetn);
    end
    checks++;
    if (doneCycle - lastWrCycle != 2) begin
      errors++;
      $display("[TB] FAIL basic_done_latency: %0d cycles after write, required 2",
               doneCycle - lastWrCycle);
    end
    checks++;
    if (imem_waddr !== 8'h01 || imem_wdata !== 16'hABCD) begin
      errors++;
      $display("[TB] FAIL basic_hold: addr=%h data=%h, required 01 abcd", imem_waddr, imem_wdata);
    end
  endtask

  // Program ending on a high byte
  task automatic test_odd();
    do_reset();
    streamBytes = '{8'h12, 8'h34, 8'h56};
    drive_stream(0, 0);
    checks++;
    if (gotWrites.size() != 2 || gotWrites[gotWrites.size()-1] !== {8'h01, 16'h5600}) begin
      errors++;
      $display("[TB] FAIL odd_write: %0d writes last=%h, required 2 writes last=015600",
               gotWrites.size(), (gotWrites.size() > 0) ? gotWrites[gotWrites.size()-1] : 24'h0);
    end
    checks++;
    if (err_odd !== 1'b1 || load_done !== 1'b1 || err_overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL odd_status: odd=%b done=%b ovf=%b, required 1 1 0",
               err_odd, load_done, err_overflow);
    end
  endtask

  // s_valid toggling every cycle
  task automatic test_stall();
    do_reset();
    streamBytes = '{8'hDE, 8'hAD};
    drive_stream(1, 0);
    checks++;
    if (gotWrites.size() != 1 || gotWrites[0] !== {8'h00, 16'hDEAD}) begin
      errors++;
      $display("[TB] FAIL stall_write: %0d writes first=%h, required 1 write 00dead",
               gotWrites.size(), (gotWrites.size() > 0) ? gotWrites[0] : 24'h0);
    end
    checks++;
    if (word_count !== 9'd1 || err_odd !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_status: cnt=%0d odd=%b, required 1 0", word_count, err_odd);
    end
  endtask

  // Back-to-back and randomly stalled random programs against the model
  task automatic test_random_loads();
    for (int t = 0; t < 6; t++) begin
      int n;
      do_reset();
      n = $urandom_range(1, 40);
      streamBytes.delete();
      for (int i = 0; i < n; i++) streamBytes.push_back(8'($urandom));
      build_expected();
      drive_stream((t % 2 == 0) ? 0 : 2, 35);
      checks++;
      if (gotWrites.size() != expWrites.size()) begin
        errors++;
        $display("[TB] FAIL rand%0d_count: %0d writes, required %0d", t, gotWrites.size(), expWrites.size());
      end else begin
        for (int i = 0; i < expWrites.size(); i++) begin
          checks++;
          if (gotWrites[i] !== expWrites[i]) begin
            errors++;
            $display("[TB] FAIL rand%0d_w%0d: got %h, required %h", t, i, gotWrites[i], expWrites[i]);
          end
        end
      end
      checks++;
      if (word_count !== 9'(expWrites.size()) || err_odd !== expOdd || err_overflow !== expOvf ||
          acceptCount != expAccepted) begin
        errors++;
        $display("[TB] FAIL rand%0d_status: cnt=%0d odd=%b ovf=%b acc=%0d, required %0d %b %b %0d",
                 t, word_count, err_odd, err_overflow, acceptCount,
                 expWrites.size(), expOdd, expOvf, expAccepted);
      end
    end
  endtask

  // 514-byte program into a 256-word memory
  task automatic test_overflow();
    do_reset();
    streamBytes.delete();
    for (int i = 0; i < 514; i++) streamBytes.push_back(8'($urandom));
    build_expected();
    drive_stream(0, 0);
    checks++;
    if (gotWrites.size() != 256) begin
      errors++;
      $display("[TB] FAIL ovf_count: %0d writes, required 256", gotWrites.size());
    end else begin
      for (int i = 0; i < 256; i++) begin
        checks++;
        if (gotWrites[i] !== expWrites[i]) begin
          errors++;
          $display("[TB] FAIL ovf_w%0d: got %h, required %h", i, gotWrites[i], expWrites[i]);
        end
      end
    end
    checks++;
    if (err_overflow !== 1'b1 || err_odd !== 1'b0 || word_count !== 9'd256) begin
      errors++;
      $display("[TB] FAIL ovf_status: ovf=%b odd=%b cnt=%0d, required 1 0 256",
               err_overflow, err_odd, word_count);
    end
    checks++;
    if (acceptCount != 512 || s_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_accept: accepted=%0d ready=%b, required 512 0", acceptCount, s_ready);
    end
  endtask

  // Reset mid-word, reset during the write cycle, reload, then reset in RUN
  task automatic test_reset_midload();
    do_reset();
    s_valid = 1'b1; s_data = 8'h77; s_last = 1'b0;
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++;
    if (imem_wren !== 1'b0 || s_ready !== 1'b0 || word_count !== 9'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset: wren=%b rdy=%b cnt=%0d, required 0 0 0", imem_wren, s_ready, word_count);
    end
    do_reset();
    s_valid = 1'b1; s_data = 8'h55; s_last = 1'b0;
    @(posedge clk); #1;
    s_data = 8'h66; s_last = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    checks++;
    if (imem_wren !== 1'b1 || imem_wdata !== 16'h5566) begin
      errors++;
      $display("[TB] FAIL write_cycle: wren=%b data=%h, required 1 5566", imem_wren, imem_wdata);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (imem_wren !== 1'b0 || imem_wdata !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL write_abort: wren=%b data=%h, required 0 0000", imem_wren, imem_wdata);
    end
    do_reset();
    streamBytes = '{8'h01, 8'h02};
    drive_stream(0, 0);
    checks++;
    if (gotWrites.size() != 1 || gotWrites[0] !== {8'h00, 16'h0102} || word_count !== 9'd1) begin
      errors++;
      $display("[TB] FAIL reload: %0d writes first=%h cnt=%0d, required 1 000102 1",
               gotWrites.size(), (gotWrites.size() > 0) ? gotWrites[0] : 24'h0, word_count);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (cpu_resetn !== 1'b0 || load_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL run_reset: rstn=%b done=%b, required 0 0", cpu_resetn, load_done);
    end
    do_reset();
  endtask

  // Test sequence
  initial begin
    test_reset();
    test_basic();
    test_odd();
    test_stall();
    test_random_loads();
    test_overflow();
    test_reset_midload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
